read_ddr_fifo_fill_ctrl: RTL and testbench

- Sequences DDR read bursts that refill the video read-side FIFO (read_ddr_fifo) for one frame at a time.
- Monitors the FIFO write-side water level and issues a burst request only when the FIFO has room for the whole burst.
- Counts returned beats and gates them into the FIFO write port.
- Sits between the DDR read-request/return interface and the read FIFO, in the DDR clock domain.

---
 rtl/read_ddr_fifo_fill_ctrl.sv | 150 +++++++++++++++
 tb/tb_read_ddr_fifo_fill_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ddr_fifo_fill_ctrl.sv
// Refills the video read FIFO from DDR for one frame at a time. A burst is
// issued only when the FIFO has room for every beat of it. Only one burst is
// ever outstanding, and returned beats are gated into the FIFO write port.
`timescale 1ns/1ps

module read_ddr_fifo_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 28,
  parameter int unsigned FIFO_DEPTH_WIDTH = 10,
  parameter int unsigned BURST_LEN        = 64,
  parameter int unsigned BEAT_BYTES       = 32,
  parameter int unsigned FRAME_BEATS      = 57600
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       frame_base,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level,
  output logic                        rd_req_valid,
  input  logic                        rd_req_ready,
  output logic [ADDR_WIDTH-1:0]       rd_req_addr,
  output logic [7:0]                  rd_req_len,
  input  logic                        rd_data_valid,
  output logic                        fifo_wr_en,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err
);

  localparam int unsigned FREE_W = FIFO_DEPTH_WIDTH + 2;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned BL_W   = $clog2(FRAME_BEATS + 1);

  localparam logic [FREE_W-1:0] CAPACITY      = FREE_W'(2 ** FIFO_DEPTH_WIDTH);
  localparam logic [BL_W-1:0]   FRAME_BEATS_W = BL_W'(FRAME_BEATS);
  localparam logic [CNT_W-1:0]  BURST_LEN_W   = CNT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [BL_W-1:0]         beats_left;
  logic [CNT_W-1:0]        burst_n;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    settle_cnt;

  logic [CNT_W-1:0]        n_c;
  logic [FREE_W-1:0]       free_c;
  logic                    room_c;
  logic                    last_beat_c;

  // Size of the next burst: full length, or whatever is left of the frame.
  always_comb begin
    n_c = BURST_LEN_W;
    if (32'(beats_left) < BURST_LEN) n_c = CNT_W'(beats_left);
  end

  assign free_c      = CAPACITY - FREE_W'(fifo_wr_water_level);
  assign room_c      = (32'(free_c) >= 32'(n_c));
  assign last_beat_c = (beat_cnt == (burst_n - CNT_W'(1)));

  // Beats reach the FIFO only while a burst is being received.
  assign fifo_wr_en  = rd_data_valid && (state == S_DATA);

  // Frame sequencer with registered request/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cur_addr     <= '0;
      beats_left   <= '0;
      burst_n      <= '0;
      beat_cnt     <= '0;
      settle_cnt   <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_len   <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && (state != S_IDLE)) err <= 1'b1;
      if (rd_data_valid && (state != S_DATA)) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            cur_addr   <= frame_base;
            beats_left <= FRAME_BEATS_W;
            settle_cnt <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Two cycles so the water level catches up with the last writes.
          if (settle_cnt) begin
            settle_cnt <= 1'b0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= 1'b1;
          end
        end
        S_CHECK: begin
          if (beats_left == '0) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else if (room_c) begin
            rd_req_addr  <= cur_addr;
            rd_req_len   <= 8'(n_c - CNT_W'(1));
            burst_n      <= n_c;
            rd_req_valid <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
            beat_cnt     <= '0;
            state        <= S_DATA;
          end
        end
        S_DATA: begin
          if (rd_data_valid) begin
            if (last_beat_c) begin
              cur_addr   <= cur_addr + ADDR_WIDTH'(32'(burst_n) * BEAT_BYTES);
              beats_left <= beats_left - BL_W'(burst_n);
              settle_cnt <= 1'b0;
              state      <= S_SETTLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_ddr_fifo_fill_ctrl.sv
// Directed bench for read_ddr_fifo_fill_ctrl: a 200-beat frame instance and a
// single-beat frame instance, driven by a simple DDR responder in tasks.
`timescale 1ns/1ps

module tb_read_ddr_fifo_fill_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rst;

  logic          frame_start;
  logic [AW-1:0] frame_base;
  logic [DW:0]   level;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [7:0]    rd_req_len;
  logic          rd_data_valid;
  logic          fifo_wr_en;
  logic          busy;
  logic          frame_done;
  logic          err;

  logic          frame_start1;
  logic [AW-1:0] frame_base1;
  logic          rd_req_valid1;
  logic [AW-1:0] rd_req_addr1;
  logic [7:0]    rd_req_len1;
  logic          rd_data_valid1;
  logic          fifo_wr_en1;
  logic          busy1;
  logic          frame_done1;
  logic          err1;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int wr_cnt1  = 0;

  always #5 clk = ~clk;

  read_ddr_fifo_fill_ctrl #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH_WIDTH(DW), .BURST_LEN(64),
    .BEAT_BYTES(32), .FRAME_BEATS(200)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
    .fifo_wr_water_level(level), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_data_valid(rd_data_valid),
    .fifo_wr_en(fifo_wr_en), .busy(busy), .frame_done(frame_done), .err(err)
  );

  read_ddr_fifo_fill_ctrl #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH_WIDTH(DW), .BURST_LEN(64),
    .BEAT_BYTES(32), .FRAME_BEATS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start1), .frame_base(frame_base1),
    .fifo_wr_water_level(11'd0), .rd_req_valid(rd_req_valid1),
    .rd_req_ready(1'b1), .rd_req_addr(rd_req_addr1),
    .rd_req_len(rd_req_len1), .rd_data_valid(rd_data_valid1),
    .fifo_wr_en(fifo_wr_en1), .busy(busy1), .frame_done(frame_done1), .err(err1)
  );

  // Count FIFO writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (fifo_wr_en)  wr_cnt  <= wr_cnt + 1;
    if (fifo_wr_en1) wr_cnt1 <= wr_cnt1 + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    frame_start = 0; frame_base = '0; level = '0; rd_req_ready = 1'b1;
    rd_data_valid = 0; frame_start1 = 0; frame_base1 = '0; rd_data_valid1 = 0;
    repeat (3) tick;
    n_checks++;
    if ({rd_req_valid, busy, frame_done, err, fifo_wr_en} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000",
               {rd_req_valid, busy, frame_done, err, fifo_wr_en});
    else n_pass++;
    n_checks++;
    if (rd_req_addr !== '0 || rd_req_len !== 8'd0)
      $display("FAIL reset_addr_len: got addr %h len %0d required 0/0", rd_req_addr, rd_req_len);
    else n_pass++;
    n_checks++;
    if ({rd_req_valid1, busy1, frame_done1, err1} !== 4'b0)
      $display("FAIL reset_dut1: got %b required 0000",
               {rd_req_valid1, busy1, frame_done1, err1});
    else n_pass++;
    rst = 1'b0;
    tick;
  endtask

  // Services all four bursts of a 200-beat frame; optionally stalls ready on
  // one burst and pulses frame_start during the data phase of another.
  task automatic run_frame(input logic [AW-1:0] base, input bit do_start,
                           input int ready_burst, input int start_burst,
                           input logic exp_err, input string tag);
    int w0;
    int k;
    int n;
    logic [AW-1:0] ea;
    logic [7:0] el;
    bit bad;
    w0 = wr_cnt;
    if (do_start) begin
      frame_base = base;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      ea = base + AW'(b * 2048);
      el = (b == 3) ? 8'd7 : 8'd63;
      n  = int'(el) + 1;
      if (b == ready_burst) rd_req_ready = 1'b0;
      k = 0;
      while (!rd_req_valid && k < 50) begin tick; k++; end
      n_checks++;
      if (rd_req_valid !== 1'b1)
        $display("FAIL %s req_valid[%0d]: got %b required 1", tag, b, rd_req_valid);
      else n_pass++;
      n_checks++;
      if (rd_req_addr !== ea)
        $display("FAIL %s req_addr[%0d]: got %h required %h", tag, b, rd_req_addr, ea);
      else n_pass++;
      n_checks++;
      if (rd_req_len !== el)
        $display("FAIL %s req_len[%0d]: got %0d required %0d", tag, b, rd_req_len, el);
      else n_pass++;
      if (b == ready_burst) begin
        bad = 1'b0;
        repeat (5) begin
          tick;
          if (rd_req_valid !== 1'b1 || rd_req_addr !== ea || rd_req_len !== el) bad = 1'b1;
        end
        n_checks++;
        if (bad)
          $display("FAIL %s req_hold: got valid %b addr %h len %0d required 1/%h/%0d",
                   tag, rd_req_valid, rd_req_addr, rd_req_len, ea, el);
        else n_pass++;
        rd_req_ready = 1'b1;
      end
      tick;
      n_checks++;
      if (rd_req_valid !== 1'b0)
        $display("FAIL %s req_drop[%0d]: got %b required 0", tag, b, rd_req_valid);
      else n_pass++;
      rd_data_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (b == start_burst && i == 5) frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
      end
      rd_data_valid = 1'b0;
    end
    tick;
    tick;
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s done_early: got done %b busy %b required 0/1", tag, frame_done, busy);
    else n_pass++;
    tick;
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s done_pulse: got done %b busy %b required 1/1", tag, frame_done, busy);
    else n_pass++;
    tick;
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s done_end: got done %b busy %b required 0/0", tag, frame_done, busy);
    else n_pass++;
    n_checks++;
    if (wr_cnt - w0 !== 200)
      $display("FAIL %s wr_count: got %0d required 200", tag, wr_cnt - w0);
    else n_pass++;
    n_checks++;
    if (err !== exp_err)
      $display("FAIL %s err: got %b required %b", tag, err, exp_err);
    else n_pass++;
  endtask

  task automatic test_frame;
    run_frame(28'h0100000, 1'b1, -1, -1, 1'b0, "frame");
  endtask

  task automatic test_level_gate;
    bit bad;
    frame_base = 28'h0200000;
    level = 11'd1000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      tick;
      if (rd_req_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL level_1000: got valid 1 required 0");
    else n_pass++;
    level = 11'd961;
    repeat (3) tick;
    n_checks++;
    if (rd_req_valid !== 1'b0)
      $display("FAIL level_961: got valid %b required 0", rd_req_valid);
    else n_pass++;
    level = 11'd960;
    tick;
    n_checks++;
    if (rd_req_valid !== 1'b1)
      $display("FAIL level_960: got valid %b required 1", rd_req_valid);
    else n_pass++;
    level = 11'd0;
    run_frame(28'h0200000, 1'b0, -1, -1, 1'b0, "level");
  endtask

  task automatic test_ready_stall;
    run_frame(28'h0300000, 1'b1, 1, -1, 1'b0, "stall");
  endtask

  task automatic test_start_in_data;
    run_frame(28'h0400000, 1'b1, -1, 2, 1'b1, "start_in_data");
  endtask

  task automatic test_reset_mid_data;
    int k;
    frame_base = 28'h0500000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    k = 0;
    while (!rd_req_valid && k < 50) begin tick; k++; end
    tick;
    rd_data_valid = 1'b1;
    repeat (10) tick;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_req_valid, busy, frame_done, err, fifo_wr_en} !== 5'b0)
      $display("FAIL mid_rst_flags: got %b required 00000",
               {rd_req_valid, busy, frame_done, err, fifo_wr_en});
    else n_pass++;
    n_checks++;
    if (rd_req_addr !== '0 || rd_req_len !== 8'd0)
      $display("FAIL mid_rst_addr_len: got %h/%0d required 0/0", rd_req_addr, rd_req_len);
    else n_pass++;
    tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if (fifo_wr_en !== 1'b0)
      $display("FAIL stray_wr_en: got %b required 0", fifo_wr_en);
    else n_pass++;
    tick;
    rd_data_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rd_req_valid !== 1'b0)
      $display("FAIL stray_err: got err %b busy %b valid %b required 1/0/0",
               err, busy, rd_req_valid);
    else n_pass++;
  endtask

  task automatic test_single_beat;
    int k;
    int w0;
    w0 = wr_cnt1;
    frame_base1 = 28'h0ABC000;
    frame_start1 = 1'b1;
    tick;
    frame_start1 = 1'b0;
    k = 0;
    while (!rd_req_valid1 && k < 50) begin tick; k++; end
    n_checks++;
    if (rd_req_valid1 !== 1'b1 || rd_req_addr1 !== 28'h0ABC000 || rd_req_len1 !== 8'd0)
      $display("FAIL single_req: got valid %b addr %h len %0d required 1/0abc000/0",
               rd_req_valid1, rd_req_addr1, rd_req_len1);
    else n_pass++;
    tick;
    rd_data_valid1 = 1'b1;
    tick;
    rd_data_valid1 = 1'b0;
    tick;
    tick;
    n_checks++;
    if (frame_done1 !== 1'b0)
      $display("FAIL single_done_early: got %b required 0", frame_done1);
    else n_pass++;
    tick;
    n_checks++;
    if (frame_done1 !== 1'b1)
      $display("FAIL single_done: got %b required 1", frame_done1);
    else n_pass++;
    tick;
    n_checks++;
    if (wr_cnt1 - w0 !== 1 || err1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL single_end: got writes %0d err %b busy %b required 1/0/0",
               wr_cnt1 - w0, err1, busy1);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_level_gate;
    test_ready_stall;
    test_start_in_data;
    test_reset_mid_data;
    test_single_beat;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
